// File: rtl/iob_axistream_arb_pkg.sv
// Shared types and helpers for the AXI-stream packet arbiter and its schedulers.
package iob_axistream_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_t;

    // Index width for an N-entry selector; a single entry still needs one bit.
    function automatic int calc_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_rr_pick.sv
// Combinational round-robin pick: the first requester after 'last', with wrap.
module iob_rr_pick
    import iob_axistream_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int ID_W = calc_id_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [ID_W-1:0] last,
    output logic            vld,
    output logic [ID_W-1:0] idx
);

    logic [ID_W-1:0] cand;

    // Scan from the furthest candidate to the nearest so the nearest one after 'last' wins
    always_comb begin
        vld  = 1'b0;
        idx  = last;
        cand = last;
        for (int k = N_CH; k >= 1; k--) begin
            cand = ID_W'((int'(last) + k) % N_CH);
            if (req[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/iob_axistream_out_arb.sv
// Packet-level round-robin arbiter: N_CH AXI-stream requesters share one registered
// output stage. A grant is held from the first beat until the tlast beat is taken.
module iob_axistream_out_arb
    import iob_axistream_arb_pkg::*;
#(
    parameter int  N_CH   = 4,
    parameter int  DATA_W = 8,
    parameter int  CNT_W  = 16,
    localparam int ID_W   = calc_id_w(N_CH)
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   en,
    input  logic [N_CH-1:0]        ch_en,
    input  logic [N_CH*DATA_W-1:0] s_tdata,
    input  logic [N_CH-1:0]        s_tvalid,
    input  logic [N_CH-1:0]        s_tlast,
    output logic [N_CH-1:0]        s_tready,
    output logic [DATA_W-1:0]      m_tdata,
    output logic                   m_tvalid,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       pkt_cnt
);

    arb_state_t        state_q;
    arb_state_t        state_nxt;
    logic [ID_W-1:0]   grant_q;
    logic [N_CH-1:0]   req;
    logic              pick_vld;
    logic [ID_W-1:0]   pick_idx;

    logic [DATA_W-1:0] sel_tdata;
    logic              sel_tvalid;
    logic              sel_tlast;
    logic              out_free;
    logic              xfer;

    logic [DATA_W-1:0] data_p0;
    logic              last_p0;
    logic              vld_p0;
    logic [CNT_W-1:0]  cnt_q;

    // Masks only gate who may win a new arbitration; they never abort a granted packet.
    assign req = en ? (s_tvalid & ch_en) : '0;

    iob_rr_pick #(
        .N_CH (N_CH),
        .ID_W (ID_W)
    ) u_pick (
        .req  (req),
        .last (grant_q),
        .vld  (pick_vld),
        .idx  (pick_idx)
    );

    // Route the granted requester's beat toward the output stage
    always_comb begin
        sel_tdata  = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_tdata  = s_tdata[i*DATA_W +: DATA_W];
                sel_tvalid = s_tvalid[i];
                sel_tlast  = s_tlast[i];
            end
        end
    end

    // The single output slot can take a new beat when empty or draining this cycle.
    assign out_free = ~vld_p0 | m_tready;
    assign xfer     = (state_q == ACTIVE) & sel_tvalid & out_free;

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state: win arbitration in IDLE, release the grant on the accepted tlast beat
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_nxt = ACTIVE;
            ACTIVE:  if (xfer && sel_tlast) state_nxt = IDLE;
        endcase
    end

    // FSM outputs: only the granted requester sees ready, and only while ACTIVE
    always_comb begin
        s_tready = '0;
        busy     = (state_q == ACTIVE);
        for (int i = 0; i < N_CH; i++) begin
            if (state_q == ACTIVE && grant_q == ID_W'(i)) begin
                s_tready[i] = out_free;
            end
        end
    end

    // Grant register; keeps the last winner after a packet so it drops to lowest priority
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            grant_q <= ID_W'(N_CH - 1);
        end else if (state_q == IDLE && pick_vld) begin
            grant_q <= pick_idx;
        end
    end

    // Output stage p0: load on an input transfer, hold under backpressure, empty once drained
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_p0 <= '0;
            last_p0 <= 1'b0;
            vld_p0  <= 1'b0;
        end else if (xfer) begin
            data_p0 <= sel_tdata;
            last_p0 <= sel_tlast;
            vld_p0  <= 1'b1;
        end else if (m_tready) begin
            vld_p0  <= 1'b0;
        end
    end

    // Packets-sent counter; clear wins over a coincident tlast acceptance
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (vld_p0 && m_tready && last_p0) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign m_tdata  = data_p0;
    assign m_tlast  = last_p0;
    assign m_tvalid = vld_p0;
    assign grant_id = grant_q;
    assign pkt_cnt  = cnt_q;

endmodule

// File: doc/iob_axistream_out_arb.md
Name: iob_axistream_out_arb

Overview:
- Packet-level round-robin arbiter sharing one byte-wide AXI-stream output (tdata/tvalid/tready/tlast) among N_CH requester streams.
- Sits in front of the AXI-stream output datapath, so several producers (CPU FIFO, DMA, test pattern) can drive one physical stream without interleaving packets.
- Grant is held from the first beat until the tlast beat is accepted.
- Output is a registered single-entry stage; a status counter reports packets sent.

Parameters:
- N_CH, 4: number of requester streams (2..16).
- DATA_W, 8: tdata width per stream.
- CNT_W, 16: width of the transmitted-packet counter.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- en  in  1  global arbitration enable.
- ch_en  in  N_CH  per-requester enable mask.
- s_tdata  in  N_CH*DATA_W  requester data; channel i occupies bits [i*DATA_W +: DATA_W].
- s_tvalid  in  N_CH  requester valid.
- s_tlast  in  N_CH  requester last-beat flag.
- s_tready  out  N_CH  requester ready.
- m_tdata  out  DATA_W  output data.
- m_tvalid  out  1  output valid.
- m_tlast  out  1  output last.
- m_tready  in  1  output ready.
- busy  out  1  state is ACTIVE.
- grant_id  out  $clog2(N_CH)  index of the current or last granted requester.
- cnt_clr  in  1  synchronous clear of pkt_cnt.
- pkt_cnt  out  CNT_W  count of tlast beats accepted at the output.

Behaviour:
- Reset values (arst_n low, asynchronous):
  - State IDLE; busy = 0.
  - m_tvalid = 0, m_tdata = 0, m_tlast = 0.
  - s_tready = 0.
  - grant_id = N_CH-1, so channel 0 has first priority.
  - pkt_cnt = 0.
- IDLE:
  - When en = 1 and any (s_tvalid & ch_en) bit is set, pick the first set index scanning grant_id+1, grant_id+2, ... with modulo-N_CH wrap.
  - Register the choice into grant_id and move to ACTIVE on the next edge.
  - Arbitration costs one bubble cycle per packet.
  - In IDLE, s_tready is all zeros.
- ACTIVE:
  - s_tready[grant_id] = (~m_tvalid | m_tready); every other s_tready bit is 0.
  - Input transfer occurs when s_tvalid[g] & s_tready[g]. On a transfer:
    - the output register loads s_tdata/s_tlast of g;
    - m_tvalid is set on the next edge.
  - If no transfer occurs and m_tready = 1, m_tvalid clears.
  - A transfer carrying tlast = 1 returns the state to IDLE on the same edge; grant_id keeps g, so g gets lowest priority next.
- Latency: input beat to m_tvalid is 1 cycle. Full throughput (one beat per cycle) holds within a packet while m_tready = 1.
- m_tdata and m_tlast stay stable while m_tvalid & ~m_tready.
- Mask changes:
  - Clearing en or ch_en[g] during ACTIVE does not abort the packet; it completes.
  - The masks only affect selection in IDLE.
- Single requester: back-to-back packets from the same channel are re-granted after one IDLE cycle.
- An s_tvalid drop mid-packet simply stalls; the grant is held indefinitely (no timeout).
- pkt_cnt:
  - Increments when m_tvalid & m_tready & m_tlast.
  - Wraps at 2^CNT_W.
  - cnt_clr has priority over a simultaneous increment; the result is 0.
- Reset mid-packet drops the in-flight packet. After release, the output shows no partial beat and arbitration restarts from channel 0.

Decomposition:
- Package iob_axistream_arb_pkg holds:
  - state enumeration (IDLE = 1'b0, ACTIVE = 1'b1);
  - function for the ID_W = $clog2(N_CH) computation.
- One natural sub-module: iob_rr_pick. It is combinational; given req[N_CH] and last[ID_W], it returns a valid flag and the next index, and is reusable by other schedulers.
- The output register stage stays inline.

Test Plan:
- Single channel: ch_en = 4'b0001; ch0 sends 3 beats 0xA1, 0xA2, 0xA3 (tlast on 0xA3) with m_tready = 1. Expect:
  - m_tvalid high for exactly 3 consecutive cycles, starting 2 cycles after first s_tvalid (arb + register);
  - m_tlast only with 0xA3;
  - pkt_cnt = 1.
- Round-robin fairness: all four channels continuously request 2-beat packets. Expect:
  - grant order 0, 1, 2, 3, 0, 1;
  - no interleaving of beats inside a packet (m_tlast every second beat);
  - pkt_cnt = 6 after 6 packets.
- Backpressure: m_tready toggles 1, 0, 0, 1 during a 4-beat packet from ch2. Expect:
  - m_tdata held stable during stalls;
  - s_tready[2] low whenever m_tvalid & ~m_tready;
  - all 4 bytes delivered in order, no loss or duplication.
- Mask change mid-packet: ch1 granted; clear ch_en[1] and en after beat 1 of 3. Expect:
  - packet completes;
  - afterwards busy = 0, no further grants while en = 0.
- Counter boundaries: preload to pkt_cnt = 0xFFFF via 65535 packets or a forced state, then send one packet → pkt_cnt = 0x0000. Assert cnt_clr on the same cycle as an output tlast beat → pkt_cnt = 0.
- Asynchronous reset: pulse arst_n low mid-packet from ch3 → m_tvalid and busy drop immediately; after release, with ch0 and ch3 both requesting, ch0 is granted first.
